// File: rtl/array_mult_unit.sv
// array_mult_unit: unsigned WIDTH x WIDTH array multiplier with a registered
// product and a valid strobe. The product is built from an AND plane of
// partial products, reduced row by row with full-adder rows in carry-save
// form, and resolved by a final ripple-carry adder.
// Build option: define MULT_PIPE_EN to register the carry-save sum/carry
// vectors ahead of the final adder, which gives 2-cycle latency instead of 1.
// Ports, arithmetic and throughput (one product per cycle) are the same in
// both builds.
module array_mult_unit #(
   parameter int WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   output logic [2*WIDTH-1:0]   p
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0] w_pp [WIDTH];
   logic [PW-1:0] w_sum;
   logic [PW-1:0] w_carry;
   logic [PW-1:0] w_row_s;
   logic [PW-1:0] w_row_c;
   logic [PW-1:0] w_cpa;

   logic [PW-1:0] r_p;
   logic          r_vld;

   // Final carry-propagate adder, written as an explicit full-adder chain.
   function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] x,
                                                input logic [PW-1:0] y);
      logic          c;
      logic [PW-1:0] s;
      c = 1'b0;
      s = '0;
      for (int k = 0; k < PW; k++) begin
         s[k] = x[k] ^ y[k] ^ c;
         c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
      end
      return s;
   endfunction

   // AND plane: row i holds a & b[i], already shifted to weight 2^i.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_pp[i] = PW'(a & {WIDTH{b[i]}}) << i;
      end
   end

   // Carry-save reduction: each further row is folded in by one row of full
   // adders. Any carry lost off the top would only matter above 2^PW, which
   // the true product never reaches, so the modulo-2^PW sum stays exact.
   always_comb begin
      w_sum   = w_pp[0];
      w_carry = '0;
      w_row_s = '0;
      w_row_c = '0;
      for (int i = 1; i < WIDTH; i++) begin
         w_row_s = w_sum ^ w_carry ^ w_pp[i];
         w_row_c = ((w_sum & w_carry) | (w_sum & w_pp[i]) | (w_carry & w_pp[i])) << 1;
         w_sum   = w_row_s;
         w_carry = w_row_c;
      end
   end

`ifdef MULT_PIPE_EN
   logic [PW-1:0] r_s;
   logic [PW-1:0] r_c;
   logic          r_v1;

   assign w_cpa = ripple_add(r_s, r_c);

   // Two stages: carry-save vectors first, resolved product second. An idle
   // cycle travels as a cleared valid; the data registers simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s   <= '0;
         r_c   <= '0;
         r_v1  <= 1'b0;
         r_p   <= '0;
         r_vld <= 1'b0;
      end else begin
         r_v1  <= in_valid;
         if (in_valid) begin
            r_s <= w_sum;
            r_c <= w_carry;
         end
         r_vld <= r_v1;
         if (r_v1) begin
            r_p <= w_cpa;
         end
      end
   end
`else
   assign w_cpa = ripple_add(w_sum, w_carry);

   // Single output register: capture the product when operands are valid,
   // otherwise keep the last product and drop the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p   <= '0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_p <= w_cpa;
         end
      end
   end
`endif

   assign p         = r_p;
   assign out_valid = r_vld;

endmodule

// File: tb/tb_array_mult_unit.sv
// Testbench for array_mult_unit: WIDTH=2 instance checked against a delay-line
// reference model, plus a WIDTH=4 instance swept over all operand pairs.
module tb_array_mult_unit;

   localparam int W = 2;
`ifdef MULT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           in_valid;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic [2*W-1:0] p;

   logic           in_valid4;
   logic [3:0]     a4;
   logic [3:0]     b4;
   logic           out_valid4;
   logic [7:0]     p4;

   array_mult_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .p(p)
   );

   array_mult_unit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .a(a4), .b(b4),
      .out_valid(out_valid4), .p(p4)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic           v;
      logic [2*W-1:0] p;
   } slot_t;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
   } vec_t;

   // Reference model: products travel through a delay line LAT deep; the
   // visible product is the last one that emerged valid.
   slot_t          pipe_q[$];
   logic           m_v;
   logic [2*W-1:0] m_p;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      slot_t z;
      z.v = 1'b0;
      z.p = '0;
      pipe_q.delete();
      repeat (LAT - 1) pipe_q.push_back(z);
      m_v = 1'b0;
      m_p = '0;
   endtask

   task automatic step(input string tag, input logic r, input logic v,
                       input logic [W-1:0] x, input logic [W-1:0] y);
      slot_t s;
      rst      = r;
      in_valid = v;
      a        = x;
      b        = y;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         s.v = v;
         s.p = (2*W)'(int'(x) * int'(y));
         pipe_q.push_back(s);
         s   = pipe_q.pop_front();
         m_v = s.v;
         if (s.v) m_p = s.p;
      end
      #1;
      check({tag, "_out_valid"}, 32'(out_valid), 32'(m_v));
      check({tag, "_p"}, 32'(p), 32'(m_p));
   endtask

   vec_t tbl[8];
   logic [W-1:0] sa[5];
   logic [W-1:0] sb[5];

   initial begin
      tbl[0] = '{a: 2'd2, b: 2'd3, exp: 4'd6};
      tbl[1] = '{a: 2'd2, b: 2'd1, exp: 4'd2};
      tbl[2] = '{a: 2'd3, b: 2'd2, exp: 4'd6};
      tbl[3] = '{a: 2'd1, b: 2'd3, exp: 4'd3};
      tbl[4] = '{a: 2'd1, b: 2'd2, exp: 4'd2};
      tbl[5] = '{a: 2'd3, b: 2'd3, exp: 4'd9};
      tbl[6] = '{a: 2'd1, b: 2'd1, exp: 4'd1};
      tbl[7] = '{a: 2'd0, b: 2'd3, exp: 4'd0};
      sa = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd1};
      sb = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd3};

      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 2'd3;
      b         = 2'd3;
      in_valid4 = 1'b0;
      a4        = '0;
      b4        = '0;
      model_reset();

      // Reset sanity: rst beats in_valid, nothing leaks out after release.
      step("rst", 1'b1, 1'b1, 2'd3, 2'd3);
      step("rst", 1'b1, 1'b1, 2'd3, 2'd3);
      repeat (LAT) step("release", 1'b0, 1'b0, 2'd3, 2'd3);

      // Directed products, each checked against its constant after LAT cycles.
      for (int i = 0; i < 8; i++) begin
         step("tbl", 1'b0, 1'b1, tbl[i].a, tbl[i].b);
         repeat (LAT - 1) step("tbl_wait", 1'b0, 1'b0, 2'd0, 2'd0);
         check("tbl_const_p", 32'(p), 32'(tbl[i].exp));
         check("tbl_const_ov", 32'(out_valid), 32'd1);
         step("tbl_idle", 1'b0, 1'b0, 2'd0, 2'd0);
      end

      // Back-to-back stream of 20 valid pairs.
      for (int i = 0; i < 20; i++) begin
         if (i < 5) step("stream", 1'b0, 1'b1, sa[i], sb[i]);
         else step("stream", 1'b0, 1'b1, W'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
      end
      repeat (LAT) step("stream_drain", 1'b0, 1'b0, 2'd0, 2'd0);

      // Idle hold after (3,3).
      step("hold", 1'b0, 1'b1, 2'd3, 2'd3);
      repeat (3) step("hold_idle", 1'b0, 1'b0, 2'd1, 2'd1);
      check("hold_p9", 32'(p), 32'd9);

      // Reset right after (3,2).
      step("midrst", 1'b0, 1'b1, 2'd3, 2'd2);
      step("midrst", 1'b1, 1'b0, 2'd0, 2'd0);
      check("midrst_p0", 32'(p), 32'd0);
      repeat (3) step("midrst_after", 1'b0, 1'b0, 2'd0, 2'd0);
      check("midrst_empty", 32'(out_valid), 32'd0);

      // Exhaustive WIDTH=2 sweep, back to back.
      for (int i = 0; i < 16; i++) begin
         step("sweep2", 1'b0, 1'b1, W'(i >> 2), W'(i & 3));
      end
      repeat (LAT) step("sweep2_drain", 1'b0, 1'b0, 2'd0, 2'd0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
              W'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
      end
      repeat (LAT) step("rand_drain", 1'b0, 1'b0, 2'd0, 2'd0);

      // Exhaustive WIDTH=4 sweep on the second instance.
      for (int k = 0; k < 256 + LAT; k++) begin
         int idx;
         in_valid4 = (k < 256);
         a4        = 4'(k >> 4);
         b4        = 4'(k & 15);
         @(posedge clk);
         #1;
         idx = k - (LAT - 1);
         if (idx >= 0 && idx < 256) begin
            check("sweep4_ov", 32'(out_valid4), 32'd1);
            check("sweep4_p", 32'(p4), 32'((idx >> 4) * (idx & 15)));
         end
      end
      check("sweep4_idle_ov", 32'(out_valid4), 32'd0);
      check("sweep4_last_p", 32'(p4), 32'd225);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/array_mult_unit.md
Name: array_mult_unit

Overview:
- Unsigned WIDTH x WIDTH integer multiplier with registered output and a valid strobe.
- Default configuration is 2x2 -> 4-bit product.
- Used as a datapath leaf that the design-space-exploration flow instantiates and characterises.
- Built as an explicit partial-product array (AND plane plus full/half-adder reduction), not an inferred "*".

Parameters:
- WIDTH, 2, operand width in bits for both a and b. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on a/b are valid this cycle
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  p holds a new product this cycle
- p  output  2*WIDTH  product, unsigned

Behaviour:
- Arithmetic:
  - p = a * b exactly, unsigned.
  - The 2*WIDTH result width cannot overflow; for WIDTH=2 the maximum is 3*3 = 9.
- Structure:
  - Partial products pp[i][j] = a[j] & b[i].
  - Reduce with rows of full/half adders (carry-save or ripple array), then a final ripple-carry adder.
  - All combinational logic is generated from WIDTH.
- Reset:
  - When rst=1 at a rising edge: p <= 0 and out_valid <= 0.
  - rst dominates in_valid in the same cycle.
  - Asserting rst mid-stream discards any in-flight product; nothing is emitted afterwards for it.
- Latency:
  - 1 clock with the macro absent.
  - Operands sampled at edge N with in_valid=1 give p and out_valid=1 after edge N, visible in cycle N+1.
- Throughput:
  - One product per cycle.
  - Back-to-back in_valid is fully supported with no bubbles.
  - There is no backpressure; the consumer must accept every out_valid pulse.
- Idle behaviour:
  - When in_valid=0, out_valid <= 0 on the next edge.
  - p holds its last value; it is not cleared.
- Other rules:
  - a and b are ignored when in_valid=0.
  - Zero operands are legal and give p=0 with out_valid=1.
  - No X propagation from unused inputs when in_valid=0.

Optional Feature:
- Macro: MULT_PIPE_EN
- Defined:
  - An extra register stage is inserted between the partial-product reduction array and the final carry-propagate adder.
  - The reduction array's sum and carry vectors plus a valid bit are registered.
  - Latency becomes 2 clocks; throughput stays one per cycle.
  - rst clears both stages, including the intermediate valid.
  - Idle cycles propagate as out_valid=0 through both stages.
- Undefined:
  - Single output register only, latency 1.
  - Port list and arithmetic are identical in both builds.

Test Plan:
- Reset sanity: rst=1 for 2 cycles with in_valid=1, a=3, b=3 -> out_valid=0 and p=0 throughout; after release, first product appears only from a newly sampled input.
- Directed products (WIDTH=2), one per cycle with in_valid=1:
  - (2,3) -> 6
  - (2,1) -> 2
  - (3,2) -> 6
  - (1,3) -> 3
  - (1,2) -> 2
  - (3,3) -> 9
  - (1,1) -> 1
  - (0,3) -> 0
  - Each result has out_valid=1 exactly 1 cycle later, or 2 with MULT_PIPE_EN.
- Back-to-back stream: 20 consecutive valid pairs such as (2,3),(2,3),(2,1),(3,2),(1,3)... -> 20 consecutive out_valid pulses, in order, matching a*b with no gaps.
- Idle hold: apply (3,3), then in_valid=0 for 3 cycles with a=1, b=1 -> p stays 9 and out_valid is 1 for a single cycle, then 0.
- Reset mid-operation: apply (3,2), then assert rst on the next edge -> no out_valid for (3,2) (relevant to the 2-stage build), p=0, and the pipeline is empty after reset.
- Exhaustive sweep: all 16 (a,b) pairs, plus a WIDTH=4 build over all 256 pairs (15*15 -> 225) -> every p equals a*b.
